// File: rtl/kyber_poly_ram.sv
// kyber_poly_ram: dual-port coefficient RAM with a pairwise clear engine.
// Optional sticky collision flag: define KYBER_RAM_COLLISION_DET_EN.
module kyber_poly_ram #(
  parameter int DATA_W   = 12,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_a,
  output logic [DATA_W-1:0] dout_b
`ifdef KYBER_RAM_COLLISION_DET_EN
  ,
  output logic              collision
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W - 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = '1;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic done_q;
  logic done_d;
  logic start_ok;
  logic clearing;

  logic              wa_en;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_din;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_din;
  logic              same_addr;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  assign clearing  = (state_q == CLEAR);
  assign busy      = clearing;
  assign clr_done  = done_q;
  assign same_addr = (addr_a == addr_b);

  // Clear engine state, pair counter and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state: accept a start in IDLE, walk pairs in CLEAR.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    start_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d  = CLEAR;
          cnt_d    = '0;
          start_ok = 1'b1;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write port steering: engine owns both ports while clearing,
  // and port B yields to port A on an address clash.
  always_comb begin
    wa_en   = 1'b0;
    wa_addr = addr_a;
    wa_din  = din_a;
    wb_en   = 1'b0;
    wb_addr = addr_b;
    wb_din  = din_b;
    unique case (1'b1)
      clearing: begin
        wa_en   = 1'b1;
        wa_addr = {cnt_q, 1'b0};
        wa_din  = '0;
        wb_en   = 1'b1;
        wb_addr = {cnt_q, 1'b1};
        wb_din  = '0;
      end
      default: begin
        wa_en = we_a;
        wb_en = we_b && !(we_a && same_addr);
      end
    endcase
  end

  // Storage array; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (rst_n && wa_en) begin
      mem[wa_addr] <= wa_din;
    end
    if (rst_n && wb_en) begin
      mem[wb_addr] <= wb_din;
    end
  end

  // First read stage: read-first, sees pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      rd_a <= mem[addr_a];
      rd_b <= mem[addr_b];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] pa_q;
      logic [DATA_W-1:0] pb_q;

      // Extra output stage for long routes to the consumer.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pa_q <= '0;
          pb_q <= '0;
        end else begin
          pa_q <= rd_a;
          pb_q <= rd_b;
        end
      end

      assign dout_a = pa_q;
      assign dout_b = pb_q;
    end else begin : g_lat1
      assign dout_a = rd_a;
      assign dout_b = rd_b;
    end
  endgenerate

`ifdef KYBER_RAM_COLLISION_DET_EN
  logic coll_q;
  logic coll_set;

  assign coll_set  = !clearing && we_a && we_b && same_addr;
  assign collision = coll_q;

  // Sticky clash flag; a new event wins over a same-cycle start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q <= 1'b0;
    end else if (coll_set) begin
      coll_q <= 1'b1;
    end else if (start_ok) begin
      coll_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_kyber_poly_ram.sv
// tb_kyber_poly_ram: directed table, clear sequences and random traffic
// against an array model; READ_LAT 1 and 2 instances share stimulus.
module tb_kyber_poly_ram;

  logic        clk;
  logic        rst_n;
  logic        clr_start;
  logic        we_a;
  logic        we_b;
  logic [7:0]  addr_a;
  logic [7:0]  addr_b;
  logic [11:0] din_a;
  logic [11:0] din_b;

  logic        busy;
  logic        clr_done;
  logic [11:0] dout_a;
  logic [11:0] dout_b;
  logic        busy2;
  logic        clr_done2;
  logic [11:0] dout_a2;
  logic [11:0] dout_b2;
`ifdef KYBER_RAM_COLLISION_DET_EN
  logic        collision;
  logic        collision2;
`endif

  kyber_poly_ram #(
    .DATA_W  (12),
    .ADDR_W  (8),
    .READ_LAT(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_start(clr_start),
    .busy     (busy),
    .clr_done (clr_done),
    .we_a     (we_a),
    .we_b     (we_b),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .din_a    (din_a),
    .din_b    (din_b),
    .dout_a   (dout_a),
    .dout_b   (dout_b)
`ifdef KYBER_RAM_COLLISION_DET_EN
    ,
    .collision(collision)
`endif
  );

  kyber_poly_ram #(
    .DATA_W  (12),
    .ADDR_W  (8),
    .READ_LAT(2)
  ) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_start(clr_start),
    .busy     (busy2),
    .clr_done (clr_done2),
    .we_a     (we_a),
    .we_b     (we_b),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .din_a    (din_a),
    .din_b    (din_b),
    .dout_a   (dout_a2),
    .dout_b   (dout_b2)
`ifdef KYBER_RAM_COLLISION_DET_EN
    ,
    .collision(collision2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [11:0] mmem [256];
  bit          mvld [256];
  bit          m_busy;
  bit          m_done;
  bit          m_coll;
  int          m_k;
  logic [11:0] ha [2];
  logic [11:0] hb [2];
  bit          hav [2];
  bit          hbv [2];
  logic [11:0] fillv [256];

  typedef struct {
    bit          wa;
    logic [7:0]  aa;
    logic [11:0] da;
    bit          wb;
    logic [7:0]  ab;
    logic [11:0] db;
    bit          c1;
    logic [11:0] ea;
    logic [11:0] eb;
    bit          c2;
    logic [11:0] ea2;
    logic [11:0] eb2;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("busy", 32'(busy), 32'(m_busy));
    chk("busy_l2", 32'(busy2), 32'(m_busy));
    chk("clr_done", 32'(clr_done), 32'(m_done));
    chk("clr_done_l2", 32'(clr_done2), 32'(m_done));
    if (hav[0]) chk("dout_a_l1", 32'(dout_a), 32'(ha[0]));
    if (hbv[0]) chk("dout_b_l1", 32'(dout_b), 32'(hb[0]));
    if (hav[1]) chk("dout_a_l2", 32'(dout_a2), 32'(ha[1]));
    if (hbv[1]) chk("dout_b_l2", 32'(dout_b2), 32'(hb[1]));
`ifdef KYBER_RAM_COLLISION_DET_EN
    chk("collision", 32'(collision), 32'(m_coll));
    chk("collision_l2", 32'(collision2), 32'(m_coll));
`endif
  endtask

  // Starts and ends at a falling edge; one rising edge in between.
  task automatic step(input bit wa, input logic [7:0] aa,
                      input logic [11:0] da, input bit wb,
                      input logic [7:0] ab, input logic [11:0] db,
                      input bit cs);
    logic [11:0] ra;
    logic [11:0] rb;
    bit          rav;
    bit          rbv;
    we_a      = wa;
    addr_a    = aa;
    din_a     = da;
    we_b      = wb;
    addr_b    = ab;
    din_b     = db;
    clr_start = cs;
    @(posedge clk);
    ra     = mmem[aa];
    rav    = mvld[aa];
    rb     = mmem[ab];
    rbv    = mvld[ab];
    m_done = 1'b0;
    if (m_busy) begin
      mmem[2*m_k]   = 12'h000;
      mvld[2*m_k]   = 1'b1;
      mmem[2*m_k+1] = 12'h000;
      mvld[2*m_k+1] = 1'b1;
      m_k++;
      if (m_k == 128) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      if (wa && wb && aa == ab) m_coll = 1'b1;
      else if (cs) m_coll = 1'b0;
      if (wb) begin
        mmem[ab] = db;
        mvld[ab] = 1'b1;
      end
      if (wa) begin
        mmem[aa] = da;
        mvld[aa] = 1'b1;
      end
      if (cs) begin
        m_busy = 1'b1;
        m_k    = 0;
      end
    end
    ha[1]  = ha[0];
    hav[1] = hav[0];
    hb[1]  = hb[0];
    hbv[1] = hbv[0];
    ha[0]  = ra;
    hav[0] = rav;
    hb[0]  = rb;
    hbv[0] = rbv;
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  // Called at a falling edge; asserts reset mid-cycle.
  task automatic apply_reset_now();
    we_a      = 1'b0;
    we_b      = 1'b0;
    clr_start = 1'b0;
    rst_n     = 1'b0;
    #1;
    m_busy = 1'b0;
    m_done = 1'b0;
    m_coll = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ha[i]  = 12'h000;
      hb[i]  = 12'h000;
      hav[i] = 1'b1;
      hbv[i] = 1'b1;
    end
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int bc;
    int dc;
    bit seen;
    logic [7:0] ra8;
    logic [7:0] rb8;

    tbl[0] = '{1, 8'd5,  12'h123, 1, 8'd6,  12'hABC, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 8'd5,  12'h000, 0, 8'd6,  12'h000,
               1, 12'h123, 12'hABC, 0, 0, 0};
    tbl[2] = '{1, 8'd10, 12'h111, 1, 8'd10, 12'h222,
               0, 0, 0, 1, 12'h123, 12'hABC};
    tbl[3] = '{0, 8'd10, 12'h000, 0, 8'd10, 12'h000,
               1, 12'h111, 12'h111, 0, 0, 0};
    tbl[4] = '{1, 8'd3,  12'h055, 0, 8'd3,  12'h000,
               0, 0, 0, 1, 12'h111, 12'h111};
    tbl[5] = '{1, 8'd3,  12'h0FF, 0, 8'd3,  12'h000,
               1, 12'h055, 12'h055, 0, 0, 0};
    tbl[6] = '{0, 8'd3,  12'h000, 0, 8'd3,  12'h000,
               1, 12'h0FF, 12'h0FF, 1, 12'h055, 12'h055};
    tbl[7] = '{0, 8'd5,  12'h000, 0, 8'd6,  12'h000,
               1, 12'h123, 12'hABC, 1, 12'h0FF, 12'h0FF};
    tbl[8] = '{0, 8'd0,  12'h000, 0, 8'd1,  12'h000,
               0, 0, 0, 1, 12'h123, 12'hABC};

    for (int i = 0; i < 256; i++) begin
      mmem[i] = 12'h000;
      mvld[i] = 1'b0;
    end
    m_k       = 0;
    rst_n     = 1'b1;
    clr_start = 1'b0;
    we_a      = 1'b0;
    we_b      = 1'b0;
    addr_a    = 8'd0;
    addr_b    = 8'd0;
    din_a     = 12'h000;
    din_b     = 12'h000;

    @(negedge clk);
    apply_reset_now();

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].wa, tbl[i].aa, tbl[i].da,
           tbl[i].wb, tbl[i].ab, tbl[i].db, 1'b0);
      if (tbl[i].c1) begin
        chk($sformatf("tbl%0d_a", i), 32'(dout_a), 32'(tbl[i].ea));
        chk($sformatf("tbl%0d_b", i), 32'(dout_b), 32'(tbl[i].eb));
      end
      if (tbl[i].c2) begin
        chk($sformatf("tbl%0d_a2", i), 32'(dout_a2), 32'(tbl[i].ea2));
        chk($sformatf("tbl%0d_b2", i), 32'(dout_b2), 32'(tbl[i].eb2));
      end
    end

    for (int i = 0; i < 128; i++) begin
      step(1, 8'(2*i), 12'($urandom), 1, 8'(2*i+1), 12'($urandom), 0);
    end
    step(1, 8'd200, 12'h5A5, 0, 8'd0, 12'h000, 1);
    bc = busy ? 1 : 0;
    step(1, 8'd200, 12'h111, 1, 8'd7, 12'h222, 1);
    chk("wr_with_start", 32'(dout_a), 32'h5A5);
    if (busy) bc++;
    dc   = 0;
    seen = 1'b0;
    for (int j = 0; j < 140 && !seen; j++) begin
      ra8 = 8'($urandom);
      rb8 = ($urandom % 4 == 0) ? ra8 : 8'($urandom);
      step(1, ra8, 12'($urandom | 1), 1, rb8, 12'($urandom | 1),
           1'($urandom % 8 == 0));
      if (busy) bc++;
      if (clr_done) begin
        dc++;
        seen = 1'b1;
      end
    end
    chk("busy_cycles", 32'(bc), 32'd128);
    chk("done_pulses", 32'(dc), 32'd1);
    step(0, 8'd0, 12'h000, 0, 8'd1, 12'h000, 0);
    chk("done_width", 32'(clr_done), 32'd0);
    for (int i = 0; i < 128; i++) begin
      step(0, 8'(2*i), 12'h000, 0, 8'(2*i+1), 12'h000, 0);
      chk("cleared_a", 32'(dout_a), 32'h000);
      chk("cleared_b", 32'(dout_b), 32'h000);
    end

    for (int i = 0; i < 128; i++) begin
      fillv[2*i]   = 12'($urandom) | 12'h001;
      fillv[2*i+1] = 12'($urandom) | 12'h001;
      step(1, 8'(2*i), fillv[2*i], 1, 8'(2*i+1), fillv[2*i+1], 0);
    end
    step(0, 8'd0, 12'h000, 0, 8'd0, 12'h000, 1);
    for (int i = 0; i < 40; i++) begin
      step(0, 8'($urandom), 12'h000, 0, 8'($urandom), 12'h000, 0);
    end
    apply_reset_now();
    chk("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 128; i++) begin
      step(0, 8'(2*i), 12'h000, 0, 8'(2*i+1), 12'h000, 0);
      chk("partial_a", 32'(dout_a),
          32'((2*i < 80) ? 12'h000 : fillv[2*i]));
      chk("partial_b", 32'(dout_b),
          32'((2*i+1 < 80) ? 12'h000 : fillv[2*i+1]));
    end

    for (int j = 0; j < 1500; j++) begin
      ra8 = 8'($urandom);
      rb8 = ($urandom % 4 == 0) ? ra8 : 8'($urandom);
      step(1'($urandom), ra8, 12'($urandom), 1'($urandom), rb8,
           12'($urandom), 1'($urandom % 60 == 0));
    end

    apply_reset_now();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
